fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_if.sv | 19 +
 rtl/fetch.sv | 85 ++++++++
 tb/tb_fetch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-to-decode handshake: fetch drives the instruction word, decode returns
// its stall (hold) and redirect (is_pc_changing) indications.
interface i_fetch_to_decode;
   logic [31:0] instruction;
   logic        hold;
   logic        is_pc_changing;

   modport fetch_out (
      output instruction,
      input  hold,
      input  is_pc_changing
   );

   modport decode_in (
      input  instruction,
      output hold,
      output is_pc_changing
   );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: waits for the memory flush, then requests pc and
// forwards returned words to decode. Optional macro: FETCH_ALIGN_CHECK_EN.
module fetch #(
   parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000,
   parameter int unsigned PC_INCREMENT    = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    has_flushed,
   input  logic                    data_valid,
   input  logic [31:0]             pc,
   input  logic [31:0]             data,
   output logic                    address_enable,
   output logic [31:0]             address,
   output logic [31:0]             next_pc,
   i_fetch_to_decode.fetch_out     outi
);

   localparam logic [31:0] PC_STEP = 32'(PC_INCREMENT);

   typedef enum logic {
      FLUSHING = 1'b0,
      FETCHING = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] instruction_q;
   logic [31:0] pc_plus;
   logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // The adder wraps naturally at 2^32.
   assign pc_plus          = pc + PC_STEP;
   assign address          = pc;
   assign address_enable   = (state == FETCHING) && !outi.hold &&
                             !outi.is_pc_changing && !misaligned;
   assign outi.instruction = instruction_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= FLUSHING;
         instruction_q <= NOP_INSTRUCTION;
         next_pc       <= 32'h0000_0000;
      end else begin
         case (state)
            FLUSHING: begin
               instruction_q <= NOP_INSTRUCTION;
               next_pc       <= 32'h0000_0000;
               if (has_flushed)
                  state <= FETCHING;
            end
            FETCHING: begin
               // Redirect beats stall, stall beats any returned data.
               if (outi.is_pc_changing) begin
                  instruction_q <= NOP_INSTRUCTION;
                  next_pc       <= pc;
               end else if (outi.hold) begin
                  instruction_q <= instruction_q;
                  next_pc       <= next_pc;
               end else if (misaligned) begin
                  instruction_q <= NOP_INSTRUCTION;
                  next_pc       <= pc;
               end else if (data_valid) begin
                  instruction_q <= data;
                  next_pc       <= pc_plus;
               end else begin
                  instruction_q <= NOP_INSTRUCTION;
                  next_pc       <= pc;
               end
            end
            default: begin
               state         <= FLUSHING;
               instruction_q <= NOP_INSTRUCTION;
               next_pc       <= 32'h0000_0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed vector table, reset sequences and
// randomized traffic against a behavioural model of the fetch rules.
module tb_fetch;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clock;
   logic        reset_n;
   logic        has_flushed;
   logic        data_valid;
   logic [31:0] pc;
   logic [31:0] data;
   logic        address_enable;
   logic [31:0] address;
   logic [31:0] next_pc;

   i_fetch_to_decode outi_if ();

   fetch dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .has_flushed    (has_flushed),
      .data_valid     (data_valid),
      .pc             (pc),
      .data           (data),
      .address_enable (address_enable),
      .address        (address),
      .next_pc        (next_pc),
      .outi           (outi_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   // model state
   bit          m_fetching;
   logic [31:0] m_instr;
   logic [31:0] m_npc;

   typedef struct {
      logic        hf;
      logic        dv;
      logic        hold;
      logic        chg;
      logic [31:0] pc;
      logic [31:0] data;
      logic        exp_ae;
      logic [31:0] exp_instr;
      logic [31:0] exp_npc;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_misaligned(input logic [31:0] p);
`ifdef FETCH_ALIGN_CHECK_EN
      return p[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   // Called at posedge+1: drive, check combinational outputs, cross the edge, check registers.
   task automatic step(input logic hf, input logic dv, input logic hd, input logic ch,
                       input logic [31:0] p, input logic [31:0] d,
                       input logic exp_ae, input logic [31:0] exp_instr,
                       input logic [31:0] exp_npc, input string tag);
      has_flushed            = hf;
      data_valid             = dv;
      outi_if.hold           = hd;
      outi_if.is_pc_changing = ch;
      pc                     = p;
      data                   = d;
      #1;
      check({tag, ".address"}, address, p);
      check({tag, ".address_enable"}, {31'b0, address_enable}, {31'b0, exp_ae});
      @(posedge clock);
      #1;
      check({tag, ".instruction"}, outi_if.instruction, exp_instr);
      check({tag, ".next_pc"}, next_pc, exp_npc);
   endtask

   // Behavioural rule set: expected request enable now, and register values after the edge.
   task automatic model(input logic hf, input logic dv, input logic hd, input logic ch,
                        input logic [31:0] p, input logic [31:0] d, output logic ae);
      ae = m_fetching && !hd && !ch && !is_misaligned(p);
      if (!m_fetching) begin
         m_instr    = NOP;
         m_npc      = 32'h0;
         m_fetching = hf;
      end else if (ch) begin
         m_instr = NOP;
         m_npc   = p;
      end else if (hd) begin
         // stalled: both registers keep their value
      end else if (is_misaligned(p) || !dv) begin
         m_instr = NOP;
         m_npc   = p;
      end else begin
         m_instr = d;
         m_npc   = p + 32'd4;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ae;
      logic        r_hf, r_dv, r_hd, r_ch;
      logic [31:0] r_pc, r_data, rnd;

      // Directed table: hf, dv, hold, chg, pc, data, ae, instr, next_pc (state already FETCHING)
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'h0000_0104};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 32'h0000_0104};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h2222_2222, 1'b0, NOP,           32'h0000_0200};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h3333_3333, 1'b1, NOP,           32'h0000_0200};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 32'h0000_0000};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0013, 1'b1, 32'h0000_0013, 32'h0000_0004};
`ifdef FETCH_ALIGN_CHECK_EN
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0000_0055, 1'b0, NOP,           32'h0000_0102};
`else
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0000_0055, 1'b1, 32'h0000_0055, 32'h0000_0106};
`endif
      vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 32'h0000_0304};

      reset_n                = 1'b1;
      has_flushed            = 1'b0;
      data_valid             = 1'b1;
      outi_if.hold           = 1'b0;
      outi_if.is_pc_changing = 1'b0;
      pc                     = 32'h0000_0100;
      data                   = 32'h1234_5678;

      // Reset takes effect before any clock edge.
      #3 reset_n = 1'b0;
      #1;
      check("reset.address_enable", {31'b0, address_enable}, 32'h0);
      check("reset.instruction", outi_if.instruction, NOP);
      check("reset.next_pc", next_pc, 32'h0);

      @(posedge clock);
      #1 reset_n = 1'b1;

      // Flush wait: nothing is requested until has_flushed is seen.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, NOP, 32'h0, "flush_wait");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, NOP, 32'h0, "flush_done");

      for (int i = 0; i < 8; i++)
         step(vecs[i].hf, vecs[i].dv, vecs[i].hold, vecs[i].chg, vecs[i].pc, vecs[i].data,
              vecs[i].exp_ae, vecs[i].exp_instr, vecs[i].exp_npc, $sformatf("vec%0d", i));

      // Reset in the middle of fetching discards the pending instruction.
      #2 reset_n = 1'b0;
      #1;
      check("midreset.instruction", outi_if.instruction, NOP);
      check("midreset.next_pc", next_pc, 32'h0);
      check("midreset.address_enable", {31'b0, address_enable}, 32'h0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      m_fetching = 1'b0;
      m_instr    = NOP;
      m_npc      = 32'h0;

      // After release the block must wait for has_flushed again.
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h7777_7777, 1'b0, NOP, 32'h0, "refetch_wait");

      for (int i = 0; i < 400; i++) begin
         r_hf = ($urandom_range(0, 3) != 0);
         r_dv = ($urandom_range(0, 3) != 0);
         r_hd = ($urandom_range(0, 3) == 0);
         r_ch = ($urandom_range(0, 6) == 0);
         rnd  = $urandom;
         case ($urandom_range(0, 19))
            0:       r_pc = 32'hFFFF_FFFC;
            1, 2:    r_pc = rnd;
            default: r_pc = {rnd[31:2], 2'b00};
         endcase
         r_data = $urandom;
         model(r_hf, r_dv, r_hd, r_ch, r_pc, r_data, ae);
         step(r_hf, r_dv, r_hd, r_ch, r_pc, r_data, ae, m_instr, m_npc, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
